// File: rtl/rsa_mont_mult_if.sv
// Request/response bundle between the exponentiation sequencer and the
// Montgomery multiplier.
interface rsa_mont_mult_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, op_a, op_b, modulus, input result, busy, done);
  modport slave  (input start, op_a, op_b, modulus, output result, busy, done);
endinterface

// File: rtl/rsa_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Takes one iteration per clock, with a fixed WIDTH+1 cycle latency.
module rsa_mont_mult #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_mont_mult_if.slave    bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, CORR} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
  } opr_t;

  state_t           state_q, state_d;
  opr_t             opr;
  logic [WIDTH:0]   p;
  logic [IW-1:0]    i;
  logic [WIDTH+1:0] u0, u1;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             last_bit;

  assign last_bit = (i == IW'(WIDTH - 1));

  // p < 2M is invariant, so p + b + m fits in WIDTH+2 bits without loss
  always_comb begin
    u0      = {1'b0, p} + (opr.a[i] ? {2'b00, opr.b} : '0);
    u1      = u0[0] ? u0 + {2'b00, opr.m} : u0;
    p_nxt   = (WIDTH+1)'(u1 >> 1);
    // p - m < M < 2^WIDTH, so the low WIDTH bits of the difference are exact
    res_nxt = (p >= {1'b0, opr.m}) ? p[WIDTH-1:0] - opr.m : p[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_bit)  state_d = CORR;
      CORR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr      <= '0;
      p        <= '0;
      i        <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          opr <= '{a: bus.op_a, b: bus.op_b, m: bus.modulus};
          p   <= '0;
          i   <= '0;
        end
        CALC: begin
          p <= p_nxt;
          i <= i + 1'b1;
        end
        CORR: begin
          result_q <= res_nxt;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != IDLE);
endmodule

// File: doc/rsa_mont_mult.md
# rsa_mont_mult

Bit-serial radix-2 Montgomery modular multiplier for the RSA datapath inside `tt_um_calonso88_rsa_top`. It consumes operands and modulus from the operand register bank. It produces P = A·B·2^-WIDTH mod M for the modular-exponentiation sequencer, which issues one multiply per square/multiply step. It uses one iteration per clock with a fixed latency, so the sequencer can run open-loop or use `done`.

## Interface
- `WIDTH`, default 8: operand/modulus width in bits; R = 2^WIDTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `op_a`  in  WIDTH  multiplicand A; requires A < M.
- `op_b`  in  WIDTH  multiplier B; requires B < M.
- `modulus`  in  WIDTH  modulus M; must be odd and ≥ 3.
- `result`  out  WIDTH  P, held stable from `done` until the next accepted `start`.
- `busy`  out  1  high while an operation is in progress (states CALC and CORR).
- `done`  out  1  one-cycle pulse when `result` is valid.

## Operation
- States: IDLE, CALC, CORR.
- IDLE:
  - On `start`=1, latch `op_a`, `op_b` and `modulus` into internal registers.
  - Clear accumulator p (WIDTH+1 bits) and bit counter i (clog2(WIDTH) bits).
  - Go to CALC.
- CALC, one iteration per cycle, with i from 0 to WIDTH-1:
  - u = p + (a[i] ? b : 0) (WIDTH+2 bits).
  - If u[0]=1, then u = u + m.
  - p ← u >> 1.
  - i ← i+1.
  - When i = WIDTH-1, go to CORR.
- Width rule: the invariant p < 2M holds throughout. A WIDTH+2-bit intermediate with no truncation is mandatory.
- CORR:
  - If p ≥ m, then `result` ← p − m; otherwise `result` ← p[WIDTH-1:0].
  - Assert `done`=1 for this edge only.
  - Return to IDLE.
- Operands are latched at start, so input changes during `busy` have no effect.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE.
- Even M: the result is unspecified, but the operation still completes with the normal latency and handshake. The block must not hang.
- A=0 or B=0 gives `result`=0.

## Timing
- Reset values: `result`=0, `busy`=0, `done`=0, FSM=IDLE, p=0, i=0.
- Let `start` be sampled at edge k:
  - `busy` is high from after edge k.
  - CALC spans edges k+1 … k+WIDTH.
  - CORR is at edge k+WIDTH+1. `done`=1 and `result` is valid after this edge.
  - `busy` falls at edge k+WIDTH+1, together with the rise of `done`.
- Latency from `start` to `done` is WIDTH+1 cycles. For WIDTH=8 this is 9 cycles.
- Throughput is one operation per WIDTH+1 cycles; back-to-back operation is supported.
- Reset asserted mid-operation aborts immediately, with no output glitch beyond the async clear.
  - All outputs go to their reset values.
  - The first `start` after reset release behaves normally.

## Test plan
All scenarios use WIDTH=8.
- Basic: M=13, A=5, B=7 -> `done` 9 cycles after `start`, `result`=1. `busy` is high for exactly 9 cycles.
- R⁻¹ check: M=13, A=1, B=1 -> `result`=3. Then M=251, A=250, B=250 -> `result`=201 (exercises the CORR subtraction path).
- Edge operands: M=255, A=254, B=254 -> `result`=1. Then M=13, A=0, B=9 -> `result`=0.
- Handshake:
  - Pulse `start` again 3 cycles into an operation with different operands -> ignored; the original result is produced.
  - Issue `start` in the `done` cycle -> accepted; the second `done` comes exactly 9 cycles later.
  - Changing `op_a`/`op_b` while `busy`=1 does not affect the result.
- Reset mid-operation: assert `rst_n`=0 at cycle 4 of a computation -> `result`=0, `busy`=0, `done`=0 immediately. After release, M=13, A=5, B=7 gives 1 after 9 cycles.
- Random: 500 random odd M in [3,255], with A,B < M -> `result` equals A·B·inv(256) mod M computed by the reference model. Latency is always 9.
